reg_pipe: RTL and testbench
===========================

REG_PIPE -- requirements
Module: reg_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning data bits per stage.
REQ-002 SHALL have parameter DEPTH, default 3, meaning number of register stages; legal range 1 to 16.
REQ-003 SHALL have parameter RST_VAL, default 0, meaning WIDTH-bit value loaded into every data register on reset.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port flush  input  1  discard all held entries.
REQ-007 SHALL have port in_valid  input  1  upstream offers in_data.
REQ-008 SHALL have port in_data  input  WIDTH  upstream payload.
REQ-009 SHALL have port in_ready  output  1  block can accept in_data this cycle.
REQ-010 SHALL have port out_valid  output  1  out_data holds a valid entry.
REQ-011 SHALL have port out_data  output  WIDTH  payload of the last stage.
REQ-012 SHALL have port out_ready  input  1  downstream accepts out_data.
REQ-013 SHALL have port count  output  clog2(DEPTH+1)  number of valid stages.

Function
REQ-014 SHALL hold DEPTH stages, each a WIDTH-bit data register plus a valid bit; stage 0 is the input side and stage DEPTH-1 drives out_data/out_valid.
REQ-015 SHALL count an input transfer when in_valid and in_ready are both 1, and an output transfer when out_valid and out_ready are both 1.
REQ-016 SHALL let stage DEPTH-1 advance when it is empty or out_ready=1; stage i<DEPTH-1 advances when it is empty or stage i+1 advances, so bubbles collapse.
REQ-017 SHALL drive in_ready = stage 0 advance condition AND NOT flush AND NOT rst; it is combinational from out_ready.
REQ-018 SHALL, on advance, load stage i+1 from stage i (data and valid) and stage 0 from in_data and in_valid&in_ready.
REQ-019 SHALL leave a data register unchanged when its stage does not load, and SHALL NOT leave any valid entry duplicated or lost.
REQ-020 SHALL give latency DEPTH cycles: an entry accepted at edge t into an empty pipe with out_ready=1 presents out_valid=1 after edge t+DEPTH-1, i.e. DEPTH edges including the accepting one.
REQ-021 SHALL sustain one transfer per cycle when out_ready=1 continuously; when full with out_ready=1, an input and an output transfer occur in the same cycle and count is unchanged.
REQ-022 SHALL update count by +1 on input-only transfer, -1 on output-only transfer, 0 on both or neither; count never exceeds DEPTH nor goes below 0.
REQ-023 SHALL, when flush=1, complete any output transfer that cycle, accept no input, and clear every valid bit at that edge; data registers are left unchanged; count becomes 0.
REQ-024 SHALL, with DEPTH=1, behave as a single register with in_ready = NOT out_valid OR out_ready.
REQ-025 SHALL keep out_data stable while out_valid=1 and out_ready=0.

Reset
REQ-026 SHALL, on any edge with rst=1, clear all valid bits, load RST_VAL into every data register, and set count=0, so that out_valid=0 and out_data=RST_VAL.
REQ-027 SHALL give rst priority over flush and over any transfer, including when asserted mid-stream.
REQ-028 SHALL drive in_ready=0 while rst=1 and in_ready=1 on the first cycle after rst deasserts.

Verification (WIDTH=8, DEPTH=3, RST_VAL=0x00)
REQ-029 Bench SHALL cover: rst=1 for 2 edges -> out_valid=0, out_data=0x00, count=0; after release, in_ready=1.
REQ-030 Bench SHALL cover: push 0x11,0x22,0x33 back-to-back with out_ready=1 -> 0x11 emerges 3 edges after acceptance, then 0x22, then 0x33 on consecutive cycles; count peaks at 3.
REQ-031 Bench SHALL cover: out_ready=0 and 4 items offered -> 3 accepted, in_ready=0 at count=3; raise out_ready -> 0x11 leaves and 0x44 enters on the same edge, count stays 3.
REQ-032 Bench SHALL cover: with out_ready=0, push 0xA1, one idle cycle, push 0xA2 -> both held in stages 2 and 1, count=2, no bubble remains.
REQ-033 Bench SHALL cover: flush=1 with count=2 and in_valid=1 -> in_ready=0, next cycle count=0, out_valid=0, the offered item is not accepted.
REQ-034 Bench SHALL cover: rst=1 while count=3 and flush=1 -> next edge count=0, out_data=0x00, out_valid=0.

Source files
------------

// File: rtl/reg_pipe.sv
// -----------------------------------------------------------------------------
// reg_pipe
//
// Purpose:
//    A DEPTH-stage pipeline of registers with valid/ready handshaking. Each
//    stage holds one WIDTH-bit data word and a valid bit. Empty stages
//    ("bubbles") are collapsed: a stage moves forward whenever the stage ahead
//    of it is empty or is itself moving. So a stalled pipe fills up completely
//    before it pushes back on the upstream side.
//
// Parameters:
//    WIDTH    data bits per stage
//    DEPTH    number of register stages (1..16)
//    RST_VAL  value loaded into every data register on reset
//
// Ports:
//    clk        single clock; all state changes on its rising edge
//    rst        synchronous, active-high reset (wins over flush and transfers)
//    flush      drop every held entry at the next edge
//    in_valid   upstream offers in_data
//    in_data    upstream payload
//    in_ready   pipe accepts in_data this cycle (combinational from out_ready)
//    out_valid  out_data holds a valid entry
//    out_data   payload of the last stage
//    out_ready  downstream accepts out_data
//    count      number of valid stages
// -----------------------------------------------------------------------------
module reg_pipe #(
   parameter int               WIDTH   = 32,
   parameter int               DEPTH   = 3,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       in_valid,
   input  logic [WIDTH-1:0]           in_data,
   output logic                       in_ready,
   output logic                       out_valid,
   output logic [WIDTH-1:0]           out_data,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int CW = $clog2(DEPTH+1);

   // Stage state
   logic             valid_reg [DEPTH];
   logic [WIDTH-1:0] data_reg  [DEPTH];
   logic [CW-1:0]    count_reg;
   logic [CW-1:0]    count_next;

   // Per-stage advance enables and the value each stage loads when it advances
   logic [DEPTH-1:0] adv;
   logic             src_valid [DEPTH];
   logic [WIDTH-1:0] src_data  [DEPTH];

   logic in_xfer;
   logic out_xfer;

   // The advance chain runs from the output back to the input. It is built in
   // one combinational block so that the ripple is one ordered evaluation,
   // not a vector that feeds back on itself.
   always_comb begin
      adv            = '0;
      adv[DEPTH-1]   = ~valid_reg[DEPTH-1] | out_ready;
      for (int i = DEPTH - 2; i >= 0; i--) begin
         adv[i] = ~valid_reg[i] | adv[i+1];
      end
   end

   // Reset and flush both block input, even though stage 0 could move.
   assign in_ready  = adv[0] & ~flush & ~rst;
   assign in_xfer   = in_valid & in_ready;
   assign out_valid = valid_reg[DEPTH-1];
   assign out_data  = data_reg[DEPTH-1];
   assign out_xfer  = out_valid & out_ready;
   assign count     = count_reg;

   // Stage 0 loads from the input port and takes a valid bit only for a real
   // transfer; every later stage loads from the stage just before it.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_src
         if (gi == 0) begin : g_head
            assign src_valid[gi] = in_xfer;
            assign src_data[gi]  = in_data;
         end else begin : g_body
            assign src_valid[gi] = valid_reg[gi-1];
            assign src_data[gi]  = data_reg[gi-1];
         end
      end
   endgenerate

   // Stage registers. Flush clears only the valid bits; the data words stay
   // where they are. A stage that does not advance keeps its data untouched,
   // which is what keeps out_data stable under back-pressure.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (rst) begin
            valid_reg[i] <= 1'b0;
            data_reg[i]  <= RST_VAL;
         end else if (flush) begin
            valid_reg[i] <= 1'b0;
         end else if (adv[i]) begin
            valid_reg[i] <= src_valid[i];
            data_reg[i]  <= src_data[i];
         end
      end
   end

   // Occupancy counter: +1 for input only, -1 for output only, unchanged for
   // both or neither. The handshakes themselves keep it within 0..DEPTH:
   // in_ready drops when every stage is full and stalled, and out_xfer needs
   // a valid last stage.
   always_comb begin
      count_next = count_reg;
      case ({in_xfer, out_xfer})
         2'b10:   count_next = count_reg + CW'(1);
         2'b01:   count_next = count_reg - CW'(1);
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_next;
      end
   end

endmodule

// File: tb/tb_reg_pipe.sv
// -----------------------------------------------------------------------------
// tb_reg_pipe
//
// Directed test of reg_pipe with WIDTH=8, DEPTH=3, RST_VAL=0x00. Inputs change
// 1 ns after each rising edge, and outputs are sampled at that time too. Every
// check goes through chk(), which prints one line per comparison.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_reg_pipe;

   localparam int WIDTH = 8;
   localparam int DEPTH = 3;

   logic             clk = 1'b0;
   logic             rst;
   logic             flush;
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_ready;
   logic [1:0]       count;

   int n_checks = 0;
   int n_fail   = 0;

   reg_pipe #(
      .WIDTH   (WIDTH),
      .DEPTH   (DEPTH),
      .RST_VAL (8'h00)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .count     (count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   // Advance to 1 ns after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Safety net: the stimulus uses fixed cycle counts, but never hang.
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected end of stimulus");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      out_ready = 1'b0;

      // ---- Reset: two edges with rst high ----
      step();
      step();
      chk("rst out_valid", 32'(out_valid), 32'd0);
      chk("rst out_data",  32'(out_data),  32'h00);
      chk("rst count",     32'(count),     32'd0);
      chk("rst in_ready",  32'(in_ready),  32'd0);
      rst = 1'b0;
      #1;
      chk("post-rst in_ready", 32'(in_ready), 32'd1);

      // ---- Streaming 0x11,0x22,0x33 with out_ready=1 ----
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 8'h11;
      step();
      chk("s1 count", 32'(count), 32'd1);
      chk("s1 out_valid", 32'(out_valid), 32'd0);
      in_data = 8'h22;
      step();
      chk("s2 count", 32'(count), 32'd2);
      chk("s2 out_valid", 32'(out_valid), 32'd0);
      in_data = 8'h33;
      step();
      chk("s3 out_valid", 32'(out_valid), 32'd1);
      chk("s3 out_data",  32'(out_data),  32'h11);
      chk("s3 count peak", 32'(count), 32'd3);
      in_valid = 1'b0;
      step();
      chk("s4 out_data", 32'(out_data), 32'h22);
      chk("s4 count",    32'(count),    32'd2);
      step();
      chk("s5 out_data", 32'(out_data), 32'h33);
      chk("s5 count",    32'(count),    32'd1);
      step();
      chk("s6 out_valid", 32'(out_valid), 32'd0);
      chk("s6 count",     32'(count),     32'd0);

      // ---- Back-pressure: fill with out_ready=0, then swap in/out ----
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'h11;
      step();
      in_data = 8'h22;
      step();
      in_data = 8'h33;
      step();
      chk("bp full count", 32'(count), 32'd3);
      chk("bp out_data",   32'(out_data), 32'h11);
      in_data = 8'h44;
      #1;
      chk("bp full in_ready", 32'(in_ready), 32'd0);
      step();
      chk("bp held count",    32'(count),    32'd3);
      chk("bp held out_data", 32'(out_data), 32'h11);
      out_ready = 1'b1;
      #1;
      chk("bp release in_ready", 32'(in_ready), 32'd1);
      step();
      chk("bp swap count",    32'(count),    32'd3);
      chk("bp swap out_data", 32'(out_data), 32'h22);
      in_valid = 1'b0;
      step();
      chk("bp drain1 out_data", 32'(out_data), 32'h33);
      step();
      chk("bp drain2 out_data", 32'(out_data), 32'h44);
      chk("bp drain2 count",    32'(count),    32'd1);
      step();
      chk("bp drain3 out_valid", 32'(out_valid), 32'd0);

      // ---- Bubble collapse: 0xA1, idle, 0xA2 with out_ready=0 ----
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'hA1;
      step();
      in_valid = 1'b0;
      step();
      in_valid = 1'b1;
      in_data  = 8'hA2;
      step();
      in_valid = 1'b0;
      step();
      chk("bub count",     32'(count),     32'd2);
      chk("bub out_data",  32'(out_data),  32'hA1);
      chk("bub in_ready",  32'(in_ready),  32'd1);
      in_valid = 1'b1;
      in_data  = 8'hB1;
      step();
      chk("bub fill count",    32'(count),    32'd3);
      chk("bub fill in_ready", 32'(in_ready), 32'd0);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      chk("bub pop out_data", 32'(out_data), 32'hA2);
      chk("bub pop count",    32'(count),    32'd2);

      // ---- Flush with count=2 and an item on offer ----
      out_ready = 1'b0;
      flush     = 1'b1;
      in_valid  = 1'b1;
      in_data   = 8'hC1;
      #1;
      chk("flush in_ready", 32'(in_ready), 32'd0);
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("flush count",     32'(count),     32'd0);
      chk("flush out_valid", 32'(out_valid), 32'd0);
      chk("flush data kept", 32'(out_data),  32'hA2);
      out_ready = 1'b1;
      step();
      step();
      step();
      chk("flush no accept out_valid", 32'(out_valid), 32'd0);
      chk("flush no accept count",     32'(count),     32'd0);

      // ---- Reset over flush with a full pipe ----
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'h01;
      step();
      in_data = 8'h02;
      step();
      in_data = 8'h03;
      step();
      chk("rf full count", 32'(count), 32'd3);
      rst       = 1'b1;
      flush     = 1'b1;
      out_ready = 1'b1;
      in_data   = 8'h04;
      #1;
      chk("rf in_ready", 32'(in_ready), 32'd0);
      step();
      chk("rf count",     32'(count),     32'd0);
      chk("rf out_data",  32'(out_data),  32'h00);
      chk("rf out_valid", 32'(out_valid), 32'd0);
      rst      = 1'b0;
      flush    = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("rf release in_ready", 32'(in_ready), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
